// File: rtl/timer_pkg.sv
// Shared types, field limits and helpers for the multi-channel HH:MM:SS.cc countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {SET_H = 2'd0, SET_M = 2'd1, SET_S = 2'd2, ARMED = 2'd3} mode_t;
  typedef enum logic [1:0] {STOPPED = 2'd0, RUNNING = 2'd1, EXPIRED = 2'd2} run_t;

  localparam int MAX_MIN   = 59;
  localparam int MAX_SEC   = 59;
  localparam int MAX_CENTI = 99;

  typedef struct packed {
    logic [5:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] centis;
  } tval_t;

  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] vmax,
                                           input logic up);
    if (up) return (v == vmax) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? vmax : v - 6'd1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: edit/arm/run FSM plus centisecond borrow-decrement of HH:MM:SS.cc.
// Latency: button or tick effect visible 1 cycle later; no backpressure (pulses are never stalled).
// Reload-on-expiry behaviour is compiled in when TIMER_RELOAD_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int MAX_HOURS = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       inc,
  input  logic       dec,
  input  logic       state,
  input  logic       start,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [6:0] centis,
  output logic [1:0] mode,
  output logic       running,
  output logic       done,
  output logic       expire_pulse
);

  localparam logic [5:0] HMAX = 6'(MAX_HOURS);

  mode_t mode_q, mode_nx;
  run_t  run_q, run_nx;
  tval_t val_q, val_nx, dec_v;
  logic  done_nx, pulse_nx;
`ifdef TIMER_RELOAD_EN
  tval_t reload_q, reload_nx;
  logic  paused_q, paused_nx;
`endif

  // A running value is never zero, so the hours borrow cannot underflow.
  always_comb begin
    dec_v = val_q;
    if (val_q.centis != 7'd0) begin
      dec_v.centis = val_q.centis - 7'd1;
    end else begin
      dec_v.centis = 7'(MAX_CENTI);
      if (val_q.seconds != 6'd0) begin
        dec_v.seconds = val_q.seconds - 6'd1;
      end else begin
        dec_v.seconds = 6'(MAX_SEC);
        if (val_q.minutes != 6'd0) begin
          dec_v.minutes = val_q.minutes - 6'd1;
        end else begin
          dec_v.minutes = 6'(MAX_MIN);
          dec_v.hours   = val_q.hours - 6'd1;
        end
      end
    end
  end

  always_comb begin
    mode_nx  = mode_q;
    run_nx   = run_q;
    val_nx   = val_q;
    done_nx  = done;
    pulse_nx = 1'b0;
`ifdef TIMER_RELOAD_EN
    reload_nx = reload_q;
    paused_nx = paused_q;
`endif
    if (state) begin
      if (run_q == STOPPED) begin
        mode_nx = mode_t'(mode_q + 2'd1);
      end else if (run_q == EXPIRED) begin
        run_nx  = STOPPED;
        mode_nx = SET_H;
      end
    end else if (start) begin
      if (mode_q == ARMED && run_q == STOPPED && val_q != '0) begin
        run_nx  = RUNNING;
        done_nx = 1'b0;
`ifdef TIMER_RELOAD_EN
        if (!paused_q) reload_nx = val_q;
`endif
      end else if (mode_q == ARMED && run_q == RUNNING) begin
        run_nx = STOPPED;
`ifdef TIMER_RELOAD_EN
        paused_nx = 1'b1;
`endif
      end
    end else if ((inc || dec) && run_q == STOPPED && mode_q != ARMED) begin
      case (mode_q)
        SET_H:   val_nx.hours   = wrap_step(val_q.hours, HMAX, inc);
        SET_M:   val_nx.minutes = wrap_step(val_q.minutes, 6'(MAX_MIN), inc);
        default: val_nx.seconds = wrap_step(val_q.seconds, 6'(MAX_SEC), inc);
      endcase
      val_nx.centis = 7'd0;
      done_nx       = 1'b0;
`ifdef TIMER_RELOAD_EN
      paused_nx = 1'b0;
`endif
    end

    // A pause on the tick cycle leaves run_nx STOPPED and so suppresses the decrement.
    if (tick && run_q == RUNNING && run_nx == RUNNING) begin
      val_nx = dec_v;
      if (dec_v == '0) begin
        done_nx  = 1'b1;
        pulse_nx = 1'b1;
`ifdef TIMER_RELOAD_EN
        val_nx = reload_q;
`else
        run_nx = EXPIRED;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= SET_H;
      run_q        <= STOPPED;
      val_q        <= '0;
      done         <= 1'b0;
      expire_pulse <= 1'b0;
`ifdef TIMER_RELOAD_EN
      reload_q <= '0;
      paused_q <= 1'b0;
`endif
    end else begin
      mode_q       <= mode_nx;
      run_q        <= run_nx;
      val_q        <= val_nx;
      done         <= done_nx;
      expire_pulse <= pulse_nx;
`ifdef TIMER_RELOAD_EN
      reload_q <= reload_nx;
      paused_q <= paused_nx;
`endif
    end
  end

  assign hours   = val_q.hours;
  assign minutes = val_q.minutes;
  assign seconds = val_q.seconds;
  assign centis  = val_q.centis;
  assign mode    = mode_q;
  assign running = (run_q == RUNNING);

endmodule

// File: rtl/multi_timer.sv
// NUM_CH countdown channels on one centisecond prescaler; buttons steer to channel `ch` when sel == SEL_CODE.
// Latency: state 1 cycle after button/tick, digit outputs combinational from registers; no backpressure.
// Define TIMER_RELOAD_EN to make channels reload and keep running on expiry.
module multi_timer
  import timer_pkg::*;
#(
  parameter int         NUM_CH    = 4,
  parameter int         TICK_DIV  = 100,
  parameter int         MAX_HOURS = 23,
  parameter logic [1:0] SEL_CODE  = 2'd2,
  localparam int        CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        sel,
  input  logic [CW-1:0]     ch,
  input  logic              inc,
  input  logic              dec,
  input  logic              state,
  input  logic              start,
  output logic [5:0]        hours,
  output logic [5:0]        minutes,
  output logic [5:0]        seconds,
  output logic [6:0]        centis,
  output logic [1:0]        mode,
  output logic [NUM_CH-1:0] running,
  output logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] expire_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic          btn_en;
  tval_t         ch_val  [NUM_CH];
  logic [1:0]    ch_mode [NUM_CH];
  tval_t         sel_val;
  logic [1:0]    sel_mode;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign btn_en = (sel == SEL_CODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc_q <= '0;
    else       presc_q <= tick ? '0 : presc_q + PW'(1);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic hit;
    assign hit = btn_en && (ch == CW'(k));

    timer_channel #(.MAX_HOURS(MAX_HOURS)) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .inc          (inc & hit),
      .dec          (dec & hit),
      .state        (state & hit),
      .start        (start & hit),
      .hours        (ch_val[k].hours),
      .minutes      (ch_val[k].minutes),
      .seconds      (ch_val[k].seconds),
      .centis       (ch_val[k].centis),
      .mode         (ch_mode[k]),
      .running      (running[k]),
      .done         (done[k]),
      .expire_pulse (expire_pulse[k])
    );
  end

  // Out-of-range ch matches no channel and the display reads zeros.
  always_comb begin
    sel_val  = '0;
    sel_mode = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch == CW'(k)) begin
        sel_val  = ch_val[k];
        sel_mode = ch_mode[k];
      end
    end
  end

  assign hours   = sel_val.hours;
  assign minutes = sel_val.minutes;
  assign seconds = sel_val.seconds;
  assign centis  = sel_val.centis;
  assign mode    = sel_mode;

endmodule
